// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter with a load scoreboard.
// NREQ requesters (ALU writeback, load return, debug) share the single
// register-file write port through round-robin valid/ready arbitration.
// The winning write is registered onto the write port. A 32-entry busy-bit
// scoreboard tracks outstanding load destinations, so the issue stage can
// stall on read-after-write hazards.
module regfile_wr_arbiter #(
    parameter int NREQ      = 3,
    parameter int LOAD_PORT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic                 reg_wr,
    output logic [4:0]           reg_wr_addr,
    output logic [31:0]          reg_wr_data,
    input  logic                 sb_set,
    input  logic [4:0]           sb_addr,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 err_double_set
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] last_src;
    logic [31:0]      sb_bits;
    logic [31:0]      sb_next;
    logic             sb_double_hit;
    logic             sb_clr_hit;

    logic             grant_vld_p0;
    logic [PTR_W-1:0] grant_idx_p0;
    logic [4:0]       grant_addr_p0;
    logic [31:0]      grant_data_p0;
    logic [PTR_W-1:0] rr_ptr_next;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [NREQ-1:0]  valid,
        input logic [PTR_W-1:0] ptr
    );
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && valid[idx]) begin
                pick  = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Stage p0: combinational round-robin grant and selection of the winner's write.
    always_comb begin
        grant_vld_p0  = |req_valid;
        grant_idx_p0  = rr_pick(req_valid, rr_ptr);
        req_ready     = '0;
        if (grant_vld_p0) begin
            req_ready[grant_idx_p0] = 1'b1;
        end
        grant_addr_p0 = req_addr[int'(grant_idx_p0)*5 +: 5];
        grant_data_p0 = req_data[int'(grant_idx_p0)*32 +: 32];
        if (grant_idx_p0 == PTR_W'(NREQ - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = grant_idx_p0 + PTR_W'(1);
        end
    end

    // Stage p0 -> p1: register the granted write onto the register-file port.
    // Writes to x0 still win arbitration, but the enable is suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wr      <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            last_src    <= '0;
            rr_ptr      <= '0;
        end else begin
            reg_wr <= grant_vld_p0 && (grant_addr_p0 != 5'd0);
            if (grant_vld_p0) begin
                reg_wr_addr <= grant_addr_p0;
                reg_wr_data <= grant_data_p0;
                last_src    <= grant_idx_p0;
                rr_ptr      <= rr_ptr_next;
            end
        end
    end

    // Scoreboard next state: a load-port commit clears, an issued load sets; set wins on a tie.
    always_comb begin
        sb_clr_hit    = reg_wr && (last_src == PTR_W'(LOAD_PORT));
        sb_double_hit = sb_set && (sb_addr != 5'd0) && sb_bits[sb_addr];
        sb_next       = sb_bits;
        if (sb_clr_hit) begin
            sb_next[reg_wr_addr] = 1'b0;
        end
        if (sb_set && (sb_addr != 5'd0)) begin
            sb_next[sb_addr] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // Scoreboard state and the sticky double-set flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_bits        <= '0;
            err_double_set <= 1'b0;
        end else begin
            sb_bits <= sb_next;
            if (sb_double_hit) begin
                err_double_set <= 1'b1;
            end
        end
    end

    assign rs1_busy = sb_bits[rs1_addr];
    assign rs2_busy = sb_bits[rs2_addr];

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: a vector table, hand-written scoreboard
// and reset sequences, and randomized traffic against a behavioural model.
module tb_regfile_wr_arbiter;

    localparam int NREQ      = 3;
    localparam int LOAD_PORT = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    req_valid;
    logic [2:0]    req_ready;
    logic [14:0]   req_addr;
    logic [95:0]   req_data;
    logic          reg_wr;
    logic [4:0]    reg_wr_addr;
    logic [31:0]   reg_wr_data;
    logic          sb_set;
    logic [4:0]    sb_addr;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          err_double_set;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.NREQ(NREQ), .LOAD_PORT(LOAD_PORT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .err_double_set(err_double_set)
    );

    typedef struct {
        logic [2:0]  v;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  rdy;
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        sb_set   = 1'b0;
        sb_addr  = 5'd0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Behavioural model state for the random phase
    int          m_ptr;
    logic        m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_src;
    bit          m_busy[32];
    logic        m_err;
    bit          pend[NREQ];
    logic [4:0]  p_addr[NREQ];
    logic [31:0] p_data[NREQ];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[1] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[2] = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b010, 1'b1, 5'd2, 32'h22222222};
        tbl[3] = '{3'b101, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b100, 1'b1, 5'd3, 32'h33333333};
        tbl[4] = '{3'b110, 5'd1, 5'd4, 5'd6, 32'h11111111, 32'h44444444, 32'h66666666, 3'b010, 1'b1, 5'd4, 32'h44444444};
        tbl[5] = '{3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0BADF00D, 3'b100, 1'b0, 5'd0, 32'h0BADF00D};
        tbl[6] = '{3'b011, 5'd8, 5'd9, 5'd0, 32'h88888888, 32'h99999999, 32'h0, 3'b001, 1'b1, 5'd8, 32'h88888888};
        tbl[7] = '{3'b001, 5'd10, 5'd0, 5'd0, 32'hAAAAAAAA, 32'h0, 32'h0, 3'b001, 1'b1, 5'd10, 32'hAAAAAAAA};
        tbl[8] = '{3'b100, 5'd0, 5'd0, 5'd31, 32'h0, 32'h0, 32'hFFFFFFFF, 3'b100, 1'b1, 5'd31, 32'hFFFFFFFF};
        tbl[9] = '{3'b010, 5'd0, 5'd17, 5'd0, 32'h0, 32'h12345678, 32'h0, 3'b010, 1'b1, 5'd17, 32'h12345678};

        // Reset then idle
        do_reset();
        #1;
        chk("reset reg_wr", 32'(reg_wr), 32'd0);
        chk("reset reg_wr_addr", 32'(reg_wr_addr), 32'd0);
        chk("reset reg_wr_data", reg_wr_data, 32'd0);
        chk("reset err_double_set", 32'(err_double_set), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            chk("reset rs1_busy", 32'(rs1_busy), 32'd0);
            chk("reset rs2_busy", 32'(rs2_busy), 32'd0);
        end
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        tick();

        // Vector table from a fresh reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].d0, tbl[i].d1, tbl[i].d2);
            #1;
            chk($sformatf("tbl[%0d] req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            tick();
            chk($sformatf("tbl[%0d] reg_wr", i), 32'(reg_wr), 32'(tbl[i].wr));
            chk($sformatf("tbl[%0d] reg_wr_addr", i), 32'(reg_wr_addr), 32'(tbl[i].wa));
            chk($sformatf("tbl[%0d] reg_wr_data", i), reg_wr_data, tbl[i].wd);
        end
        idle_inputs();
        tick();
        chk("tbl tail reg_wr", 32'(reg_wr), 32'd0);

        // All three requesters valid continuously: grants rotate 0,1,2,...
        do_reset();
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rotate req_ready", 32'(req_ready), 32'(1 << (k % 3)));
            tick();
            chk("rotate reg_wr", 32'(reg_wr), 32'd1);
            chk("rotate reg_wr_addr", 32'(reg_wr_addr), 32'((k % 3) + 1));
            chk("rotate reg_wr_data", reg_wr_data,
                (k % 3 == 0) ? 32'hA0A0A0A0 : (k % 3 == 1) ? 32'hB1B1B1B1 : 32'hC2C2C2C2);
        end

        // Write to x0 from requester 2: granted, suppressed, pointer wraps to 0
        drive(3'b001, 5'd12, 5'd0, 5'd0, 32'h00000012, 32'h0, 32'h0);
        tick();
        drive(3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h5555AAAA);
        #1;
        chk("x0 req_ready", 32'(req_ready), 32'b100);
        tick();
        chk("x0 reg_wr", 32'(reg_wr), 32'd0);
        chk("x0 reg_wr_data", reg_wr_data, 32'h5555AAAA);
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
        #1;
        chk("x0 ptr wrapped", 32'(req_ready), 32'b001);
        idle_inputs();
        tick();

        // Scoreboard set, load-port clear, and re-set on the clear edge
        do_reset();
        sb_set = 1'b1; sb_addr = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd0;
        #1;
        chk("sb before set", 32'(rs1_busy), 32'd0);
        tick();
        sb_set = 1'b0;
        #1;
        chk("sb set x7", 32'(rs1_busy), 32'd1);
        drive(3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'hCAFE0007, 32'h0);
        #1;
        chk("sb load ready", 32'(req_ready), 32'b010);
        tick();
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        chk("sb load reg_wr", 32'(reg_wr), 32'd1);
        chk("sb busy during write", 32'(rs1_busy), 32'd1);
        tick();
        chk("sb cleared", 32'(rs1_busy), 32'd0);
        sb_set = 1'b1; sb_addr = 5'd7;
        tick();
        sb_set = 1'b0;
        drive(3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'hCAFE0077, 32'h0);
        tick();
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        sb_set = 1'b1; sb_addr = 5'd7;
        chk("sb reset-edge reg_wr", 32'(reg_wr), 32'd1);
        tick();
        sb_set = 1'b0;
        #1;
        chk("sb set wins over clear", 32'(rs1_busy), 32'd1);
        tick();
        chk("sb stays set", 32'(rs1_busy), 32'd1);
        sb_set = 1'b1; sb_addr = 5'd0;
        tick();
        sb_set = 1'b0;
        #1;
        chk("sb x0 never busy", 32'(rs2_busy), 32'd0);

        // Double set of x9, then reset with a write in flight
        do_reset();
        rs2_addr = 5'd9;
        sb_set = 1'b1; sb_addr = 5'd9;
        tick();
        chk("dbl first set err", 32'(err_double_set), 32'd0);
        chk("dbl busy x9", 32'(rs2_busy), 32'd1);
        tick();
        sb_set = 1'b0;
        chk("dbl second set err", 32'(err_double_set), 32'd1);
        repeat (3) tick();
        chk("dbl err sticky", 32'(err_double_set), 32'd1);
        drive(3'b001, 5'd4, 5'd0, 5'd0, 32'h44440004, 32'h0, 32'h0);
        tick();
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        chk("inflight reg_wr", 32'(reg_wr), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst reg_wr", 32'(reg_wr), 32'd0);
        chk("async rst err", 32'(err_double_set), 32'd0);
        chk("async rst reg_wr_addr", 32'(reg_wr_addr), 32'd0);
        chk("async rst busy", 32'(rs2_busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the behavioural model
        do_reset();
        m_ptr = 0; m_wr = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_src = 0; m_err = 1'b0;
        for (int a = 0; a < 32; a++) m_busy[a] = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; p_addr[i] = 5'd0; p_data[i] = 32'd0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int win;
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i]) begin
                    if ($urandom_range(0, 4) == 0) pend[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    pend[i]   = 1'b1;
                    p_addr[i] = 5'($urandom_range(0, 7));
                    p_data[i] = $urandom;
                end
            end
            drive({pend[2], pend[1], pend[0]}, p_addr[0], p_addr[1], p_addr[2],
                  p_data[0], p_data[1], p_data[2]);
            sb_set   = ($urandom_range(0, 3) == 0);
            sb_addr  = 5'($urandom_range(0, 7));
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            #1;
            win = -1;
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (win < 0 && pend[idx]) win = idx;
            end
            chk("rnd req_ready", 32'(req_ready), (win >= 0) ? 32'(1 << win) : 32'd0);
            chk("rnd rs1_busy", 32'(rs1_busy), 32'(m_busy[rs1_addr]));
            chk("rnd rs2_busy", 32'(rs2_busy), 32'(m_busy[rs2_addr]));
            chk("rnd reg_wr", 32'(reg_wr), 32'(m_wr));
            chk("rnd reg_wr_addr", 32'(reg_wr_addr), 32'(m_addr));
            chk("rnd reg_wr_data", reg_wr_data, m_data);
            chk("rnd err_double_set", 32'(err_double_set), 32'(m_err));
            // Advance the model across the coming clock edge
            if (sb_set && sb_addr != 5'd0 && m_busy[sb_addr]) m_err = 1'b1;
            if (m_wr && m_src == LOAD_PORT) m_busy[m_addr] = 1'b0;
            if (sb_set && sb_addr != 5'd0) m_busy[sb_addr] = 1'b1;
            if (win >= 0) begin
                m_wr   = (p_addr[win] != 5'd0);
                m_addr = p_addr[win];
                m_data = p_data[win];
                m_src  = win;
                m_ptr  = (win + 1) % NREQ;
                pend[win] = 1'b0;
            end else begin
                m_wr = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
